// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debounce bank.
// Widths below are for the default board parameters; instances derive their own via cnt_width().
package key_pkg;

    localparam int DEF_STABLE_CYCLES = 120000;
    localparam int DEF_HOLD_CYCLES   = 12000000;
    localparam int DEF_REPEAT_CYCLES = 2400000;

    // One spare bit so a counter can hold its terminal value without wrapping.
    function automatic int cnt_width(input int v);
        return $clog2(v) + 1;
    endfunction

    localparam int CNT_W  = cnt_width(DEF_STABLE_CYCLES);
    localparam int HOLD_W = cnt_width(DEF_HOLD_CYCLES);
    localparam int REP_W  = cnt_width(DEF_REPEAT_CYCLES);

    typedef struct packed {
        logic level;
        logic neg;
        logic pos;
        logic hold;
        logic rpt;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, stable-count debounce, press/release strobes, long-press and auto-repeat.
// Level changes STABLE_CYCLES+1 edges after the pin is first sampled; no backpressure, outputs are registered.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_raw,
    input  logic     i_repeat_en,
    output key_evt_t o_evt
);

    localparam int STAB_W = cnt_width(STABLE_CYCLES);
    localparam int HLD_W  = cnt_width(HOLD_CYCLES);
    localparam int RPT_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0]  HOLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [HLD_W-1:0]  HOLD_MAX  = HLD_W'(HOLD_CYCLES);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic              state;
    logic [STAB_W-1:0] cnt;
    logic [HLD_W-1:0]  hcnt;
    logic [RPT_W-1:0]  rcnt;
    logic              hold;
    logic              neg;
    logic              pos;
    logic              rpt;

    logic flip;
    logic state_nxt;
    logic hold_nxt;
    logic rpt_nxt;

    // Next-state terms let hold and repeat clear in the same cycle the level falls.
    always_comb begin
        flip      = (s2 != state) && (cnt == STAB_LAST);
        state_nxt = flip ? s2 : state;
        hold_nxt  = state_nxt && state && (hcnt >= HOLD_LAST);
        rpt_nxt   = i_repeat_en && hold_nxt && (!hold || (rcnt == RPT_LAST));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= 1'b0;
            cnt   <= '0;
            hcnt  <= '0;
            rcnt  <= '0;
            hold  <= 1'b0;
            neg   <= 1'b0;
            pos   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            s1    <= i_raw;
            s2    <= s1;
            state <= state_nxt;

            if ((s2 == state) || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + STAB_W'(1);
            end

            if (!state_nxt) begin
                hcnt <= '0;
            end else if (state && (hcnt != HOLD_MAX)) begin
                hcnt <= hcnt + HLD_W'(1);
            end

            if (!i_repeat_en || !hold_nxt || rpt_nxt) begin
                rcnt <= '0;
            end else begin
                rcnt <= rcnt + RPT_W'(1);
            end

            hold <= hold_nxt;
            neg  <= flip && s2;
            pos  <= flip && !s2;
            rpt  <= rpt_nxt;
        end
    end

    always_comb begin
        o_evt.level = state;
        o_evt.neg   = neg;
        o_evt.pos   = pos;
        o_evt.hold  = hold;
        o_evt.rpt   = rpt;
    end

endmodule

// File: rtl/key_debounce_bank.sv
// N independent debounced key channels with press/release strobes, long-press and auto-repeat.
// Latency STABLE_CYCLES+1 edges from first pin sample to o_level; no backpressure.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_in,
    input  logic [N_KEYS-1:0] i_repeat_en,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_neg,
    output logic [N_KEYS-1:0] o_pos,
    output logic [N_KEYS-1:0] o_hold,
    output logic [N_KEYS-1:0] o_repeat
);

    localparam logic POL = (ACTIVE_LOW != 0);

    // Normalised so that 1 = pressed before anything is registered.
    logic [N_KEYS-1:0] raw;
    assign raw = i_in ^ {N_KEYS{POL}};

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_evt_t evt;

        key_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_raw       (raw[i]),
            .i_repeat_en (i_repeat_en[i]),
            .o_evt       (evt)
        );

        assign o_level[i]  = evt.level;
        assign o_neg[i]    = evt.neg;
        assign o_pos[i]    = evt.pos;
        assign o_hold[i]   = evt.hold;
        assign o_repeat[i] = evt.rpt;
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed checks of the debounce bank with small counts: press, bounce, long press/repeat, release, reset.
module tb_key_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic [1:0] ren;
    logic [1:0] level;
    logic [1:0] neg;
    logic [1:0] pos;
    logic [1:0] hold;
    logic [1:0] rpt;

    int edge_n;
    int n_err;
    int n_chk;

    always #5 clk = ~clk;

    key_debounce_bank #(
        .N_KEYS        (2),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (5),
        .ACTIVE_LOW    (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in        (in),
        .i_repeat_en (ren),
        .o_level     (level),
        .o_neg       (neg),
        .o_pos       (pos),
        .o_hold      (hold),
        .o_repeat    (rpt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // Pins released, reset held for three edges; the next edge becomes edge 0.
    task automatic start();
        rst = 1'b1;
        in  = 2'b11;
        ren = 2'b00;
        repeat (3) step();
        check("reset_outputs", {level, neg, pos, hold, rpt}, 32'h0);
        rst    = 1'b0;
        edge_n = -1;
    endtask

    initial begin
        n_err  = 0;
        n_chk  = 0;
        edge_n = 0;
        rst    = 1'b1;
        in     = 2'b11;
        ren    = 2'b00;

        // Clean press on channel 0.
        start();
        run_to(9);
        in[0] = 1'b0;
        run_to(14);
        check("press_level_early", level, 2'b00);
        run_to(15);
        check("press_level", level, 2'b01);
        check("press_neg", neg, 2'b01);
        run_to(16);
        check("press_neg_one_cycle", neg, 2'b00);
        check("press_level_held", level, 2'b01);
        check("press_pos_quiet", pos, 2'b00);

        // Bounce: low 3, high 1, five times, then high.
        start();
        run_to(9);
        for (int r = 0; r < 5; r++) begin
            in[0] = 1'b0;
            repeat (3) begin
                step();
                check("bounce_quiet", {level, neg, pos}, 32'h0);
            end
            in[0] = 1'b1;
            step();
            check("bounce_quiet", {level, neg, pos}, 32'h0);
        end
        repeat (10) begin
            step();
            check("bounce_settle", {level, neg, pos}, 32'h0);
        end

        // Long press with repeat on channel 0, then release sampled at edge 50.
        start();
        ren = 2'b01;
        run_to(9);
        in[0] = 1'b0;
        for (int e = 10; e <= 62; e++) begin
            run_to(e);
            check("lp_level", level[0], (e >= 15 && e <= 54) ? 1 : 0);
            check("lp_hold", hold[0], (e >= 35 && e <= 54) ? 1 : 0);
            check("lp_pos", pos[0], (e == 55) ? 1 : 0);
            if (e != 50)
                check("lp_repeat", rpt[0], (e >= 35 && e <= 45 && (e - 35) % 5 == 0) ? 1 : 0);
            check("lp_ch1_quiet", {level[1], hold[1], rpt[1]}, 32'h0);
            if (e == 49) in[0] = 1'b1;
        end

        // Long press with repeat disabled.
        start();
        run_to(9);
        in[0] = 1'b0;
        for (int e = 10; e <= 45; e++) begin
            run_to(e);
            check("norep_repeat", rpt, 2'b00);
            check("norep_hold", hold[0], (e >= 35) ? 1 : 0);
        end

        // Both channels pressed together; channel 1 released at edge 20.
        start();
        run_to(9);
        in = 2'b00;
        run_to(15);
        check("sim_neg", neg, 2'b11);
        check("sim_level", level, 2'b11);
        run_to(19);
        in[1] = 1'b1;
        run_to(24);
        check("sim_pos_early", pos, 2'b00);
        run_to(25);
        check("sim_pos", pos, 2'b10);
        check("sim_level_after", level, 2'b01);
        check("sim_neg_quiet", neg, 2'b00);

        // Reset while key is held.
        start();
        run_to(9);
        in[0] = 1'b0;
        run_to(15);
        check("rmp_level", level, 2'b01);
        run_to(29);
        rst = 1'b1;
        run_to(30);
        check("rmp_in_reset", {level, neg, pos, hold, rpt}, 32'h0);
        run_to(31);
        check("rmp_in_reset", {level, neg, pos, hold, rpt}, 32'h0);
        rst = 1'b0;
        run_to(36);
        check("rmp_level_early", level, 2'b00);
        check("rmp_neg_early", neg, 2'b00);
        run_to(37);
        check("rmp_level", level, 2'b01);
        check("rmp_neg", neg, 2'b01);
        run_to(38);
        check("rmp_neg_one_cycle", neg, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
